// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Instruction-fetch stage sitting right after the branch-condition
//   generator. Holds the architectural fetch PC, selects redirect targets
//   from the 3-bit PC_SEL code, runs a one-outstanding request/grant/response
//   handshake with instruction memory, and buffers returned instructions in
//   a small FIFO for decode. FLUSHED tells the branch-condition generator
//   that a redirect has taken effect.
//
//   Parameters
//     RESET_PC   PC loaded on reset
//     BUF_DEPTH  instruction FIFO entries (2 or 4)
//
//   Ports
//     CLK, RST_N                      clock (rising edge), async active-low reset
//     PC_SEL                          0=PC+4 1=JALR 2=BRANCH 3=JAL 4=trap, 5-7 as 0
//     JALR_TGT/BRANCH_TGT/JAL_TGT/MTVEC  redirect targets
//     IMEM_REQ/IMEM_ADDR              fetch request and address (current PC)
//     IMEM_GNT                        request accepted this cycle
//     IMEM_RVALID/IMEM_RDATA          instruction response
//     IF_VALID/IF_INSTR/IF_PC         FIFO head towards decode
//     ID_READY                        decode accepts the head
//     FLUSHED                         one-cycle pulse following a redirect
//
//   Optional feature (macro IF_MISALIGN_TRAP_EN)
//     Adds MISALIGN_VEC input and IF_MISALIGN output. A non-trap redirect to
//     a target with nonzero low bits loads MISALIGN_VEC instead and pulses
//     IF_MISALIGN together with FLUSHED. Without the macro the low target
//     bits are simply cleared.

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  PC_SEL,
    input  logic [31:0] JALR_TGT,
    input  logic [31:0] BRANCH_TGT,
    input  logic [31:0] JAL_TGT,
    input  logic [31:0] MTVEC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    input  logic        ID_READY,
`ifdef IF_MISALIGN_TRAP_EN
    input  logic [31:0] MISALIGN_VEC,
    output logic        IF_MISALIGN,
`endif
    output logic        FLUSHED
);

    localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t         state_q;
    logic [31:0]    pc_q;
    logic [31:0]    infl_pc_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic           flushed_q;

    // FIFO storage carries data only, so it is not reset.
    logic [31:0]    buf_pc    [BUF_DEPTH];
    logic [31:0]    buf_instr [BUF_DEPTH];

    logic           redirect;
    logic [31:0]    tgt_raw;
    logic [31:0]    redirect_pc_d;
    logic           grant;
    logic           push;
    logic           pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        redirect = (PC_SEL >= 3'd1) && (PC_SEL <= 3'd4);
        tgt_raw  = '0;
        case (PC_SEL)
            3'd1:    tgt_raw = JALR_TGT;
            3'd2:    tgt_raw = BRANCH_TGT;
            3'd3:    tgt_raw = JAL_TGT;
            3'd4:    tgt_raw = MTVEC;
            default: tgt_raw = '0;
        endcase
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign;
    logic misalign_q;

    // Trap redirects are never diverted, even if MTVEC is misaligned.
    assign misalign      = (tgt_raw[1:0] != 2'b00) && (PC_SEL != 3'd4);
    assign redirect_pc_d = misalign ? MISALIGN_VEC : (tgt_raw & 32'hFFFF_FFFC);
    assign IF_MISALIGN   = misalign_q;
`else
    assign redirect_pc_d = tgt_raw & 32'hFFFF_FFFC;
`endif

    // RST_N gates the request so it reads 0 while reset is held.
    assign IMEM_REQ  = RST_N && (state_q == S_IDLE) && (count_q < FULL_CNT) && !redirect;
    assign IMEM_ADDR = pc_q;
    assign grant     = IMEM_REQ && IMEM_GNT;

    // A redirect cancels both the push and the pop of its cycle.
    assign push = (state_q == S_WAIT) && IMEM_RVALID && !redirect;
    assign pop  = (count_q != '0) && ID_READY && !redirect;

    assign IF_VALID = (count_q != '0);
    assign IF_INSTR = IF_VALID ? buf_instr[rd_ptr_q] : '0;
    assign IF_PC    = IF_VALID ? buf_pc[rd_ptr_q]    : '0;
    assign FLUSHED  = flushed_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            infl_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            flushed_q  <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            flushed_q  <= redirect;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= redirect && misalign;
`endif
            if (redirect) begin
                pc_q     <= redirect_pc_d;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                // The outstanding response, if any, must still be absorbed.
                case (state_q)
                    S_WAIT:    state_q <= IMEM_RVALID ? S_IDLE : S_DISCARD;
                    S_DISCARD: state_q <= IMEM_RVALID ? S_IDLE : S_DISCARD;
                    default:   state_q <= S_IDLE;
                endcase
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (grant) begin
                            infl_pc_q <= pc_q;
                            pc_q      <= pc_q + 32'd4;
                            state_q   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (IMEM_RVALID) state_q <= S_IDLE;
                    end
                    S_DISCARD: begin
                        if (IMEM_RVALID) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase

                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            buf_pc[wr_ptr_q]    <= infl_pc_q;
            buf_instr[wr_ptr_q] <= IMEM_RDATA;
        end
    end

    // Requests are gated on free space, so a push into a full FIFO can only
    // come with a same-cycle pop.
    a_no_push_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
        !(push && (count_q == FULL_CNT) && !pop));

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] MVEC   = 32'h0000_0080;

    logic        CLK;
    logic        RST_N;
    logic [2:0]  PC_SEL;
    logic [31:0] JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        ID_READY;
    logic        FLUSHED;
`ifdef IF_MISALIGN_TRAP_EN
    logic [31:0] MISALIGN_VEC;
    logic        IF_MISALIGN;
`endif

    fetch_pc_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .PC_SEL(PC_SEL),
        .JALR_TGT(JALR_TGT), .BRANCH_TGT(BRANCH_TGT), .JAL_TGT(JAL_TGT), .MTVEC(MTVEC),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .ID_READY(ID_READY),
`ifdef IF_MISALIGN_TRAP_EN
        .MISALIGN_VEC(MISALIGN_VEC), .IF_MISALIGN(IF_MISALIGN),
`endif
        .FLUSHED(FLUSHED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int delivered = 0;

    // Scoreboard: instructions decode should see, oldest first ({pc, instr}).
    logic [63:0] exp_q[$];
    bit          exp_flushed = 1'b0;
    bit          exp_mis     = 1'b0;
    bit          cur_redirect = 1'b0;
    bit          mon_en = 1'b0;

    // Transaction-level model of the fetch stream.
    logic [31:0] m_pc;
    bit          outst;
    bit          dead;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    int          lat;

    // Effects that become visible after the coming clock edge.
    bit          pend_redir, pend_mis, pend_push;
    logic [63:0] pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT-presented outputs against the scoreboard.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("flushed", {31'd0, FLUSHED}, {31'd0, exp_flushed});
`ifdef IF_MISALIGN_TRAP_EN
            check("if_misalign", {31'd0, IF_MISALIGN}, {31'd0, exp_mis});
`endif
            check("if_valid", {31'd0, IF_VALID}, {31'd0, (exp_q.size() != 0)});
            if (IF_VALID && ID_READY && !cur_redirect && exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("if_pc", IF_PC, e[63:32]);
                check("if_instr", IF_INSTR, e[31:0]);
                delivered++;
            end
        end
    end

    function automatic logic [31:0] pick_tgt();
        case ($urandom_range(3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 | {28'd0, 4'($urandom_range(15))};
            2:       return 32'h0000_0200;
            default: return 32'h0000_0303;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc        = RST_PC;
        outst       = 1'b0;
        dead        = 1'b0;
        lat         = 0;
        pend_redir  = 1'b0;
        pend_mis    = 1'b0;
        pend_push   = 1'b0;
        exp_flushed = 1'b0;
        exp_mis     = 1'b0;
        cur_redirect = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        mon_en = 1'b0;
        @(posedge CLK);
        #3;
        RST_N       = 1'b0;
        PC_SEL      = 3'd0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        ID_READY    = 1'b0;
        model_reset();
        #1;
        check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
        check("rst_addr", IMEM_ADDR, RST_PC);
        check("rst_if_valid", {31'd0, IF_VALID}, 32'd0);
        check("rst_flushed", {31'd0, FLUSHED}, 32'd0);
        check("rst_if_instr", IF_INSTR, 32'd0);
        check("rst_if_pc", IF_PC, 32'd0);
        repeat (hold) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        // Stray response right after reset: must be ignored in IDLE.
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        mon_en = 1'b1;
    endtask

    task automatic cycle(input int rdy_pct, input int redir_pct);
        logic [2:0]  sel;
        logic [31:0] raw;
        bit          redirect, resp, req_exp, gnt;

        @(posedge CLK);
        if (pend_redir)     exp_q.delete();
        else if (pend_push) exp_q.push_back(pend_data);
        exp_flushed = pend_redir;
        exp_mis     = pend_mis;
        pend_redir  = 1'b0;
        pend_mis    = 1'b0;
        pend_push   = 1'b0;

        #1;
        sel        = ($urandom_range(99) < redir_pct) ? 3'($urandom_range(1, 7)) : 3'd0;
        JALR_TGT   = pick_tgt();
        BRANCH_TGT = pick_tgt();
        JAL_TGT    = pick_tgt();
        MTVEC      = pick_tgt();
        redirect   = (sel >= 3'd1) && (sel <= 3'd4);
        resp       = 1'b0;
        if (outst) begin
            if (lat == 0) resp = 1'b1;
            else          lat--;
        end
        PC_SEL      = sel;
        ID_READY    = ($urandom_range(99) < rdy_pct);
        IMEM_RVALID = resp || (!outst && $urandom_range(15) == 0);
        IMEM_RDATA  = resp ? out_data : $urandom;
        IMEM_GNT    = 1'b0;
        cur_redirect = redirect;

        #1;
        req_exp = !outst && (exp_q.size() < DEPTH) && !redirect;
        check("imem_req", {31'd0, IMEM_REQ}, {31'd0, req_exp});
        check("imem_addr", IMEM_ADDR, m_pc);
        gnt      = ($urandom_range(3) != 0);
        IMEM_GNT = gnt;

        if (resp) begin
            if (!dead && !redirect) begin
                pend_push = 1'b1;
                pend_data = {out_addr, out_data};
            end
            outst = 1'b0;
        end
        if (req_exp && gnt) begin
            outst    = 1'b1;
            dead     = 1'b0;
            out_addr = m_pc;
            out_data = $urandom;
            lat      = $urandom_range(0, 3);
            m_pc     = m_pc + 32'd4;
        end
        if (redirect) begin
            case (sel)
                3'd1:    raw = JALR_TGT;
                3'd2:    raw = BRANCH_TGT;
                3'd3:    raw = JAL_TGT;
                default: raw = MTVEC;
            endcase
            pend_redir = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            if (raw[1:0] != 2'b00 && sel != 3'd4) begin
                m_pc     = MVEC;
                pend_mis = 1'b1;
            end else begin
                m_pc = {raw[31:2], 2'b00};
            end
`else
            m_pc = {raw[31:2], 2'b00};
`endif
            if (outst) dead = 1'b1;
        end
    endtask

    initial begin
        RST_N       = 1'b1;
        PC_SEL      = 3'd0;
        JALR_TGT    = '0;
        BRANCH_TGT  = '0;
        JAL_TGT     = '0;
        MTVEC       = '0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = '0;
        ID_READY    = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        MISALIGN_VEC = MVEC;
`endif
        model_reset();

        do_reset(2);
        repeat (200)  cycle(100, 0);   // straight-line fetch from RESET_PC
        repeat (40)   cycle(0, 0);     // decode stalled: FIFO fills, requests stop
        repeat (40)   cycle(100, 0);   // drain and resume
        repeat (1500) cycle(60, 15);   // mixed redirects and back-pressure
        do_reset(3);                   // reset mid-operation
        repeat (600)  cycle(50, 25);

        @(negedge CLK);
        n_vec++;
        if (delivered < 100) begin
            n_err++;
            $display("FAIL delivered_count: got %0d expected at least 100", delivered);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
